// File: rtl/riscv_core_pkg.sv
// Shared core definitions: register address width, default datapath width
// and the writeback queue entry layout.
package riscv_core_pkg;

   localparam int REG_ADDR_W     = 5;
   localparam int DATA_WIDTH_DEF = 32;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_W-1:0]     addr;
      logic [DATA_WIDTH_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue for the writeback arbiter. Entries can be invalidated by
// destination address; invalidated entries still occupy a slot until popped.
// Optional macro WB_FWD_EN adds two address lookups returning the youngest
// valid matching entry.
module wb_fifo
   import riscv_core_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [REG_ADDR_W-1:0] i_push_addr,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   input  logic                  i_kill,
   input  logic [REG_ADDR_W-1:0] i_kill_addr,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_head_valid,
   output logic [REG_ADDR_W-1:0] o_head_addr,
   output logic [DATA_WIDTH-1:0] o_head_data
`ifdef WB_FWD_EN
   ,
   input  logic [REG_ADDR_W-1:0] i_lk_addr1,
   input  logic [REG_ADDR_W-1:0] i_lk_addr2,
   output logic                  o_lk_hit1,
   output logic                  o_lk_hit2,
   output logic [DATA_WIDTH-1:0] o_lk_data1,
   output logic [DATA_WIDTH-1:0] o_lk_data2
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]      r_valid;
   logic [REG_ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   // A push is refused when full even if the head leaves on the same edge
   assign o_full       = (r_count == CNT_W'(DEPTH));
   assign o_empty      = (r_count == '0);
   assign w_push       = i_push & ~o_full;
   assign w_pop        = i_pop & ~o_empty;
   assign o_head_valid = r_valid[r_rd_ptr] & ~o_empty;
   assign o_head_addr  = r_addr[r_rd_ptr];
   assign o_head_data  = r_data[r_rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Valid bits: kill by address first so a same-edge push stays valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && r_addr[i] == i_kill_addr) r_valid[i] <= 1'b0;
         end
         if (w_push) r_valid[r_wr_ptr] <= 1'b1;
      end
   end

   // Payload storage needs no reset; it is qualified by the valid bits
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= i_push_addr;
         r_data[r_wr_ptr] <= i_push_data;
      end
   end

`ifdef WB_FWD_EN
   // Oldest-to-youngest scan so the last match is the youngest entry
   function automatic logic [DATA_WIDTH:0] lookup(input logic [REG_ADDR_W-1:0] a);
      logic [DATA_WIDTH:0] res;
      logic [PTR_W-1:0]    idx;
      res = '0;
      for (int j = 0; j < DEPTH; j++) begin
         idx = r_rd_ptr + PTR_W'(j);
         if (CNT_W'(j) < r_count && r_valid[idx] && r_addr[idx] == a)
            res = {1'b1, r_data[idx]};
      end
      return res;
   endfunction

   // Lookup ports for forwarding
   always_comb begin
      {o_lk_hit1, o_lk_data1} = lookup(i_lk_addr1);
      {o_lk_hit2, o_lk_data2} = lookup(i_lk_addr2);
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between same-cycle ALU results and queued
// load results, with a starvation bound on queued results and write-after-write
// invalidation of stale loads. Optional macro WB_FWD_EN adds two forwarding
// lookup ports.
module wb_arbiter
   import riscv_core_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_en,
   input  logic                  alu_wr_en,
   input  logic [REG_ADDR_W-1:0] alu_wr_addr,
   input  logic [DATA_WIDTH-1:0] alu_wr_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  rf_wr_en,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic                  wb_stall,
   output logic                  wb_busy
`ifdef WB_FWD_EN
   ,
   input  logic [REG_ADDR_W-1:0] fwd_addr1,
   input  logic [REG_ADDR_W-1:0] fwd_addr2,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic [DATA_WIDTH-1:0] fwd_data1,
   output logic [DATA_WIDTH-1:0] fwd_data2
`endif
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);

   logic                  w_full;
   logic                  w_empty;
   logic                  w_head_valid;
   logic [REG_ADDR_W-1:0] w_head_addr;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_alu_win;
   logic                  w_starve;
   logic [SC_W-1:0]       r_starve_cnt;

   // Outputs are gated by rst_n so they read 0 throughout reset
   assign lsu_ready = rst_n & ~w_full;
   assign w_push    = lsu_valid & lsu_ready & (lsu_addr != '0);
   assign wb_busy   = ~w_empty;
   assign w_starve  = ~w_empty & (r_starve_cnt == SC_W'(STARVE_MAX));

   // Writeback source selection, highest priority first
   always_comb begin
      w_pop     = 1'b0;
      w_alu_win = 1'b0;
      wb_stall  = 1'b0;
      if (rst_n && !stall_en) begin
         if (w_starve) begin
            w_pop    = 1'b1;
            wb_stall = alu_wr_en;
         end else if (alu_wr_en && alu_wr_addr != '0) begin
            w_alu_win = 1'b1;
         end else if (!w_empty) begin
            w_pop = 1'b1;
         end
      end
   end

   assign rf_wr_en   = w_alu_win | (w_pop & w_head_valid);
   assign rf_wr_addr = w_alu_win ? alu_wr_addr : w_head_addr;
   assign rf_wr_data = w_alu_win ? alu_wr_data : w_head_data;

   // Cycles the head has waited unserved; frozen while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (w_pop || w_empty) begin
         r_starve_cnt <= '0;
      end else if (!stall_en && !w_starve) begin
         r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
   end

`ifdef WB_FWD_EN
   logic                  w_qhit1;
   logic                  w_qhit2;
   logic [DATA_WIDTH-1:0] w_qdata1;
   logic [DATA_WIDTH-1:0] w_qdata2;
   logic                  w_cur1;
   logic                  w_cur2;

   // The committing write is newer than anything queued, so it wins
   always_comb begin
      w_cur1    = rf_wr_en && (rf_wr_addr == fwd_addr1);
      w_cur2    = rf_wr_en && (rf_wr_addr == fwd_addr2);
      fwd_hit1  = (fwd_addr1 != '0) && (w_cur1 || w_qhit1);
      fwd_hit2  = (fwd_addr2 != '0) && (w_cur2 || w_qhit2);
      fwd_data1 = w_cur1 ? rf_wr_data : w_qdata1;
      fwd_data2 = w_cur2 ? rf_wr_data : w_qdata2;
   end
`endif

   wb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_addr  (lsu_addr),
      .i_push_data  (lsu_data),
      .i_pop        (w_pop),
      .i_kill       (w_alu_win),
      .i_kill_addr  (alu_wr_addr),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_head_valid (w_head_valid),
      .o_head_addr  (w_head_addr),
      .o_head_data  (w_head_data)
`ifdef WB_FWD_EN
      ,
      .i_lk_addr1   (fwd_addr1),
      .i_lk_addr2   (fwd_addr2),
      .o_lk_hit1    (w_qhit1),
      .o_lk_hit2    (w_qhit2),
      .o_lk_data1   (w_qdata1),
      .o_lk_data2   (w_qdata2)
`endif
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (default build, forwarding disabled).
module tb_wb_arbiter;
   import riscv_core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_en = 1'b0;
   logic        alu_wr_en = 1'b0;
   logic [4:0]  alu_wr_addr = '0;
   logic [31:0] alu_wr_data = '0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic [4:0]  lsu_addr = '0;
   logic [31:0] lsu_data = '0;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        wb_stall;
   logic        wb_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;
   logic [31:0] shadow [32];

   wb_arbiter #(.DATA_WIDTH(32), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_en    (stall_en),
      .alu_wr_en   (alu_wr_en),
      .alu_wr_addr (alu_wr_addr),
      .alu_wr_data (alu_wr_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_addr    (lsu_addr),
      .lsu_data    (lsu_data),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .wb_stall    (wb_stall),
      .wb_busy     (wb_busy)
   );

   always #5 clk = ~clk;

   // Register file image built from observed writes
   always @(posedge clk) begin
      if (rf_wr_en) begin
         shadow[rf_wr_addr] <= rf_wr_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lsu(input wb_entry_t e);
      lsu_valid = e.valid;
      lsu_addr  = e.addr;
      lsu_data  = e.data;
   endtask

   task automatic drive_alu(input logic en, input logic [4:0] a, input logic [31:0] d);
      alu_wr_en   = en;
      alu_wr_addr = a;
      alu_wr_data = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_alu(1'b1, 5'd3, 32'h55);
      drive_lsu('{valid:1'b1, addr:5'd4, data:32'h1});
      step();
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en, wb_stall, wb_busy} !== 4'b0000)
         $display("FAIL reset_outputs: got %b exp 0000", {lsu_ready, rf_wr_en, wb_stall, wb_busy});
      else n_pass++;
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      drive_lsu('0);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en, wb_busy} !== 3'b100)
         $display("FAIL ready_after_reset: got %b exp 100", {lsu_ready, rf_wr_en, wb_busy});
      else n_pass++;
   endtask

   task automatic test_load_write();
      step();
      drive_lsu('{valid:1'b1, addr:5'd5, data:32'hDEADBEEF});
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en} !== 2'b10)
         $display("FAIL load_accept: got %b exp 10", {lsu_ready, rf_wr_en});
      else n_pass++;
      step();
      drive_lsu('0);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data, wb_busy} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1})
         $display("FAIL load_write: got %b %0d %h busy %b exp 1 5 deadbeef busy 1",
                  rf_wr_en, rf_wr_addr, rf_wr_data, wb_busy);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_busy} !== 2'b00)
         $display("FAIL load_drained: got %b exp 00", {rf_wr_en, wb_busy});
      else n_pass++;
   endtask

   task automatic test_starvation();
      step();
      drive_lsu('{valid:1'b1, addr:5'd7, data:32'h77});
      step();
      drive_lsu('0);
      drive_alu(1'b1, 5'd3, 32'h11);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rf_wr_en, wb_stall, rf_wr_addr, rf_wr_data} !== {1'b1, 1'b0, 5'd3, 32'h11})
            $display("FAIL starve_alu_cycle%0d: got en %b stall %b x%0d=%h exp en 1 stall 0 x3=11",
                     i, rf_wr_en, wb_stall, rf_wr_addr, rf_wr_data);
         else n_pass++;
         step();
      end
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_stall, rf_wr_addr, rf_wr_data} !== {1'b1, 1'b1, 5'd7, 32'h77})
         $display("FAIL starve_queue_wins: got en %b stall %b x%0d=%h exp en 1 stall 1 x7=77",
                  rf_wr_en, wb_stall, rf_wr_addr, rf_wr_data);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_stall, rf_wr_addr, wb_busy} !== {1'b1, 1'b0, 5'd3, 1'b0})
         $display("FAIL starve_after: got en %b stall %b x%0d busy %b exp 1 0 x3 0",
                  rf_wr_en, wb_stall, rf_wr_addr, wb_busy);
      else n_pass++;
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
   endtask

   task automatic test_waw();
      drive_lsu('{valid:1'b1, addr:5'd9, data:32'hAA});
      step();
      drive_lsu('0);
      drive_alu(1'b1, 5'd9, 32'hBB);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd9, 32'hBB})
         $display("FAIL waw_alu_write: got %b x%0d=%h exp 1 x9=bb", rf_wr_en, rf_wr_addr, rf_wr_data);
      else n_pass++;
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_busy} !== 2'b01)
         $display("FAIL waw_killed_pop: got en %b busy %b exp 0 1", rf_wr_en, wb_busy);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (wb_busy !== 1'b0 || shadow[9] !== 32'hBB)
         $display("FAIL waw_final: got busy %b x9=%h exp 0 bb", wb_busy, shadow[9]);
      else n_pass++;
      step();
      drive_lsu('{valid:1'b1, addr:5'd9, data:32'hCC});
      drive_alu(1'b1, 5'd9, 32'hDD);
      step();
      drive_lsu('0);
      drive_alu(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd9, 32'hCC})
         $display("FAIL waw_same_edge_push: got %b x%0d=%h exp 1 x9=cc", rf_wr_en, rf_wr_addr, rf_wr_data);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      // cycle: lsu_ready, rf_wr_en, wb_stall, rf_wr_addr
      logic [7:0] exp_full [5];
      exp_full[0] = {1'b0, 1'b1, 1'b0, 5'd3};
      exp_full[1] = {1'b0, 1'b1, 1'b0, 5'd3};
      exp_full[2] = {1'b0, 1'b1, 1'b0, 5'd3};
      exp_full[3] = {1'b0, 1'b1, 1'b1, 5'd10};
      exp_full[4] = {1'b1, 1'b1, 1'b0, 5'd3};
      drive_alu(1'b1, 5'd3, 32'h11);
      drive_lsu('{valid:1'b1, addr:5'd10, data:32'h1});
      step();
      drive_lsu('{valid:1'b1, addr:5'd11, data:32'h2});
      step();
      drive_lsu('{valid:1'b1, addr:5'd12, data:32'h3});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({lsu_ready, rf_wr_en, wb_stall, rf_wr_addr} !== exp_full[i])
            $display("FAIL backpressure_cycle%0d: got rdy %b en %b stall %b x%0d exp %b",
                     i, lsu_ready, rf_wr_en, wb_stall, rf_wr_addr, exp_full[i]);
         else n_pass++;
         step();
      end
      drive_lsu('0);
      drive_alu(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en, rf_wr_addr} !== {1'b0, 1'b1, 5'd11})
         $display("FAIL drain_x11: got rdy %b en %b x%0d exp 0 1 x11", lsu_ready, rf_wr_en, rf_wr_addr);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en, rf_wr_addr} !== {1'b1, 1'b1, 5'd12})
         $display("FAIL drain_x12: got rdy %b en %b x%0d exp 1 1 x12", lsu_ready, rf_wr_en, rf_wr_addr);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (wb_busy !== 1'b0 || shadow[11] !== 32'h2 || shadow[12] !== 32'h3)
         $display("FAIL drain_final: got busy %b x11=%h x12=%h exp 0 2 3", wb_busy, shadow[11], shadow[12]);
      else n_pass++;
      step();
   endtask

   task automatic test_stall();
      drive_lsu('{valid:1'b1, addr:5'd20, data:32'h20});
      step();
      drive_lsu('0);
      drive_alu(1'b1, 5'd3, 32'h11);
      stall_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rf_wr_en, wb_busy} !== 2'b01)
            $display("FAIL stall_cycle%0d: got en %b busy %b exp 0 1", i, rf_wr_en, wb_busy);
         else n_pass++;
         step();
      end
      stall_en = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_stall, rf_wr_addr} !== {1'b1, 1'b0, 5'd3})
         $display("FAIL stall_release_alu: got en %b stall %b x%0d exp 1 0 x3", rf_wr_en, wb_stall, rf_wr_addr);
      else n_pass++;
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd20, 32'h20})
         $display("FAIL stall_queue_write: got %b x%0d=%h exp 1 x20=20", rf_wr_en, rf_wr_addr, rf_wr_data);
      else n_pass++;
      step();
   endtask

   task automatic test_zero_addr();
      drive_lsu('{valid:1'b1, addr:5'd0, data:32'h123});
      drive_alu(1'b1, 5'd0, 32'h456);
      @(negedge clk);
      n_checks++;
      if ({lsu_ready, rf_wr_en, wb_busy} !== 3'b100)
         $display("FAIL zero_addr_same: got %b exp 100", {lsu_ready, rf_wr_en, wb_busy});
      else n_pass++;
      step();
      drive_lsu('0);
      drive_alu(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({rf_wr_en, wb_busy} !== 2'b00)
         $display("FAIL zero_addr_next: got %b exp 00", {rf_wr_en, wb_busy});
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      int saved;
      drive_alu(1'b1, 5'd3, 32'h11);
      drive_lsu('{valid:1'b1, addr:5'd13, data:32'hD});
      step();
      drive_lsu('{valid:1'b1, addr:5'd14, data:32'hE});
      step();
      drive_lsu('0);
      @(negedge clk);
      n_checks++;
      if ({wb_busy, lsu_ready} !== 2'b10)
         $display("FAIL pre_reset_full: got busy %b rdy %b exp 1 0", wb_busy, lsu_ready);
      else n_pass++;
      #1;
      rst_n = 1'b0;
      drive_alu(1'b0, 5'd0, 32'h0);
      #1;
      n_checks++;
      if ({wb_busy, lsu_ready, rf_wr_en} !== 3'b000)
         $display("FAIL reset_mid_outputs: got %b exp 000", {wb_busy, lsu_ready, rf_wr_en});
      else n_pass++;
      step();
      step();
      rst_n = 1'b1;
      saved = wr_cnt;
      repeat (4) step();
      @(negedge clk);
      n_checks++;
      if (wr_cnt != saved || wb_busy !== 1'b0 || lsu_ready !== 1'b1)
         $display("FAIL post_reset_idle: got writes %0d busy %b rdy %b exp 0 0 1",
                  wr_cnt - saved, wb_busy, lsu_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_write();
      test_starvation();
      test_waw();
      test_back_to_back();
      test_stall();
      test_zero_addr();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
